boreal_symbol_dwell_filter: RTL and testbench

Sits directly downstream of the symbolic decoder. Consumes the per-sample symbolic state stream (IDLE/MOVE_X/MOVE_Y/SELECT) and debounces it with a dwell-time confirmation FSM. Generates auto-repeat for held moves and enforces a refractory period after SELECT. Confirmed actions are buffered in a small command FIFO with a valid/ready handshake to the Action/Decision VM.

---
 rtl/boreal_symbol_dwell_filter_if.sv | 27 ++
 rtl/boreal_symbol_dwell_filter.sv | 234 +++++++++++++++++++++++
 tb/tb_boreal_symbol_dwell_filter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/boreal_symbol_dwell_filter_if.sv
`default_nettype none
// ============================================================================
// Module   : boreal_symbol_dwell_filter_if
// Brief    : Command handshake bus from the dwell filter to the decision VM.
// Revision : 1.0 - initial release
// ============================================================================
interface boreal_symbol_dwell_filter_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_code;
  logic       cmd_repeat;

  modport master (
    output cmd_valid,
    output cmd_code,
    output cmd_repeat,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_code,
    input  cmd_repeat,
    output cmd_ready
  );
endinterface
`default_nettype wire

// File: rtl/boreal_symbol_dwell_filter.sv
`default_nettype none
// ============================================================================
// Module   : boreal_symbol_dwell_filter
// Brief    : Dwell-time debounce, auto-repeat and SELECT refractory filter for
//            the symbolic state stream, feeding a small command FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module boreal_symbol_dwell_filter #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         valid_in,
  input  logic [2:0]                   state_id,
  input  logic [CNT_W-1:0]             cfg_dwell,
  input  logic [CNT_W-1:0]             cfg_repeat,
  input  logic [CNT_W-1:0]             cfg_refractory,
  input  logic                         clear_ovf,
  boreal_symbol_dwell_filter_if.master cmd,
  output logic                         overflow,
  output logic [7:0]                   drop_cnt
);

  localparam int               c_aw      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [c_aw:0]    c_depth   = (c_aw+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_zero    = '0;

  localparam logic [1:0] c_track   = 2'd0;
  localparam logic [1:0] c_held    = 2'd1;
  localparam logic [1:0] c_refract = 2'd2;

  localparam logic [1:0] c_sym_idle   = 2'd0;
  localparam logic [1:0] c_sym_select = 2'd3;

  // FSM registers
  logic [1:0]       r_state;
  logic [1:0]       r_cand;
  logic [CNT_W-1:0] r_cand_cnt;
  logic [CNT_W-1:0] r_rep_cnt;
  logic [CNT_W-1:0] r_ref_cnt;

  logic [1:0]       w_nxt_state;
  logic [1:0]       w_nxt_cand;
  logic [CNT_W-1:0] w_nxt_cand_cnt;
  logic [CNT_W-1:0] w_nxt_rep_cnt;
  logic [CNT_W-1:0] w_nxt_ref_cnt;

  logic             w_push;
  logic [1:0]       w_push_code;
  logic             w_push_rep;
  logic             w_do_track;

  // FIFO registers
  logic [1:0]       r_mem_code [FIFO_DEPTH];
  logic             r_mem_rep  [FIFO_DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_count;

  logic             w_cmd_valid;
  logic             w_full;
  logic             w_pop;
  logic             w_accept;
  logic             w_drop;

  // Symbol decode and effective thresholds
  logic [1:0]       w_sym;
  logic [CNT_W-1:0] w_dwell;
  logic             w_match;
  logic             w_cand_sat;
  logic [CNT_W-1:0] w_trk_cnt;
  logic             w_trk_fire;
  logic [CNT_W-1:0] w_rep_inc;

  assign w_sym      = state_id[2] ? c_sym_idle : state_id[1:0];
  assign w_dwell    = (cfg_dwell == c_zero) ? c_one : cfg_dwell;
  assign w_match    = (w_sym == r_cand);
  assign w_cand_sat = (r_cand_cnt >= w_dwell);
  assign w_rep_inc  = r_rep_cnt + c_one;

  // Candidate tracking also serves a HELD mismatch: there w_match is 0, so
  // the sample simply restarts as a fresh candidate with count 1.
  always_comb begin
    w_trk_cnt = c_one;
    if (w_match) begin
      w_trk_cnt = w_cand_sat ? w_dwell : (r_cand_cnt + c_one);
    end
  end

  assign w_trk_fire = (w_trk_cnt == w_dwell) && !(w_match && w_cand_sat);

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_cand     = r_cand;
    w_nxt_cand_cnt = r_cand_cnt;
    w_nxt_rep_cnt  = r_rep_cnt;
    w_nxt_ref_cnt  = r_ref_cnt;
    w_push         = 1'b0;
    w_push_code    = 2'd0;
    w_push_rep     = 1'b0;
    w_do_track     = 1'b0;

    if (!enable) begin
      w_nxt_state    = c_track;
      w_nxt_cand     = c_sym_idle;
      w_nxt_cand_cnt = c_zero;
    end else if (valid_in) begin
      case (r_state)
        c_held: begin
          if (!w_match) begin
            w_do_track = 1'b1;
          end else if (cfg_repeat != c_zero) begin
            if (w_rep_inc >= cfg_repeat) begin
              w_push        = 1'b1;
              w_push_code   = r_cand;
              w_push_rep    = 1'b1;
              w_nxt_rep_cnt = c_zero;
            end else begin
              w_nxt_rep_cnt = w_rep_inc;
            end
          end
        end
        c_refract: begin
          if (r_ref_cnt <= c_one) begin
            w_nxt_ref_cnt  = c_zero;
            w_nxt_state    = c_track;
            w_nxt_cand     = c_sym_idle;
            w_nxt_cand_cnt = c_zero;
          end else begin
            w_nxt_ref_cnt = r_ref_cnt - c_one;
          end
        end
        default: begin
          w_do_track = 1'b1;
        end
      endcase

      if (w_do_track) begin
        w_nxt_state    = c_track;
        w_nxt_cand     = w_sym;
        w_nxt_cand_cnt = w_trk_cnt;
        if (w_trk_fire && (w_sym != c_sym_idle)) begin
          w_push      = 1'b1;
          w_push_code = w_sym;
          w_push_rep  = 1'b0;
          if (w_sym == c_sym_select) begin
            if (cfg_refractory != c_zero) begin
              w_nxt_state   = c_refract;
              w_nxt_ref_cnt = cfg_refractory;
            end
          end else begin
            w_nxt_state   = c_held;
            w_nxt_rep_cnt = c_zero;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_track;
      r_cand     <= c_sym_idle;
      r_cand_cnt <= '0;
      r_rep_cnt  <= '0;
      r_ref_cnt  <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_cand     <= w_nxt_cand;
      r_cand_cnt <= w_nxt_cand_cnt;
      r_rep_cnt  <= w_nxt_rep_cnt;
      r_ref_cnt  <= w_nxt_ref_cnt;
    end
  end

  // Command FIFO: no bypass, and a pop frees a slot for a same-cycle push.
  assign w_cmd_valid = (r_count != '0);
  assign w_full      = (r_count == c_depth);
  assign w_pop       = w_cmd_valid && cmd.cmd_ready;
  assign w_accept    = w_push && (!w_full || w_pop);
  assign w_drop      = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem_code[r_wr_ptr] <= w_push_code;
      r_mem_rep[r_wr_ptr]  <= w_push_rep;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // clear_ovf takes priority over a coincident drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (w_drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hff) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  assign cmd.cmd_valid  = w_cmd_valid;
  assign cmd.cmd_code   = w_cmd_valid ? r_mem_code[r_rd_ptr] : 2'd0;
  assign cmd.cmd_repeat = w_cmd_valid ? r_mem_rep[r_rd_ptr]  : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_boreal_symbol_dwell_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_boreal_symbol_dwell_filter
// Brief    : Directed scoreboard bench for boreal_symbol_dwell_filter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_boreal_symbol_dwell_filter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        valid_in;
  logic [2:0]  state_id;
  logic [11:0] cfg_dwell;
  logic [11:0] cfg_repeat;
  logic [11:0] cfg_refractory;
  logic        clear_ovf;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int n_vec = 0;
  int n_err = 0;
  logic [2:0] exp_q[$];

  boreal_symbol_dwell_filter_if cmd_if ();

  boreal_symbol_dwell_filter #(
    .FIFO_DEPTH(4),
    .CNT_W     (12)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .valid_in      (valid_in),
    .state_id      (state_id),
    .cfg_dwell     (cfg_dwell),
    .cfg_repeat    (cfg_repeat),
    .cfg_refractory(cfg_refractory),
    .clear_ovf     (clear_ovf),
    .cmd           (cmd_if),
    .overflow      (overflow),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every handshake pops one expected {code, repeat}.
  always @(negedge clk) begin
    if (rst_n && cmd_if.cmd_valid && cmd_if.cmd_ready) begin
      logic [2:0] e;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_cmd: got code=%0d rep=%0d, expected none",
                 cmd_if.cmd_code, cmd_if.cmd_repeat);
      end else begin
        e = exp_q.pop_front();
        if ({cmd_if.cmd_code, cmd_if.cmd_repeat} != e) begin
          n_err++;
          $display("FAIL cmd: got code=%0d rep=%0d, expected code=%0d rep=%0d",
                   cmd_if.cmd_code, cmd_if.cmd_repeat, e[2:1], e[0]);
        end
      end
    end
  end

  task automatic smp(input logic [2:0] s, input bit exp_push,
                     input logic [1:0] code, input bit rep);
    if (exp_push) exp_q.push_back({code, rep});
    @(negedge clk);
    valid_in = 1'b1;
    state_id = s;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Dropping enable returns the FSM to TRACK with an IDLE candidate.
  task automatic gap();
    enable = 1'b0;
    idle(2);
    enable = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; valid_in = 1'b0; state_id = 3'd0;
    cfg_dwell = 12'd1; cfg_repeat = 12'd0; cfg_refractory = 12'd0;
    clear_ovf = 1'b0; cmd_if.cmd_ready = 1'b1;
    #12;
    check("rst_valid",  int'(cmd_if.cmd_valid),  0);
    check("rst_code",   int'(cmd_if.cmd_code),   0);
    check("rst_repeat", int'(cmd_if.cmd_repeat), 0);
    check("rst_ovf",    int'(overflow),          0);
    check("rst_drop",   int'(drop_cnt),          0);
    @(posedge clk); #1; rst_n = 1'b1;
    idle(1);

    // 1: single confirmation, 1-cycle latency, no repeat
    cfg_dwell = 12'd3; cfg_repeat = 12'd0;
    smp(3'd1, 0, 2'd0, 0); check("t1_lat_s1", int'(cmd_if.cmd_valid), 0);
    smp(3'd1, 0, 2'd0, 0); check("t1_lat_s2", int'(cmd_if.cmd_valid), 0);
    smp(3'd1, 1, 2'd1, 0); check("t1_lat_s3", int'(cmd_if.cmd_valid), 1);
    smp(3'd1, 0, 2'd0, 0);
    smp(3'd1, 0, 2'd0, 0);
    idle(3);
    check("t1_drain", exp_q.size(), 0);
    gap();

    // 2: auto-repeat every 4 samples
    cfg_dwell = 12'd2; cfg_repeat = 12'd4;
    for (int i = 1; i <= 12; i++)
      smp(3'd2, (i == 2) || (i == 6) || (i == 10), 2'd2, i != 2);
    idle(3);
    check("t2_drain", exp_q.size(), 0);
    gap();

    // 3: SELECT refractory
    cfg_dwell = 12'd2; cfg_repeat = 12'd0; cfg_refractory = 12'd5;
    for (int i = 1; i <= 10; i++)
      smp(3'd3, (i == 2) || (i == 9), 2'd3, 0);
    idle(3);
    check("t3_drain", exp_q.size(), 0);
    gap();

    // 4: alternating symbols never confirm (out-of-range ids mixed in as IDLE)
    cfg_dwell = 12'd2;
    for (int i = 1; i <= 10; i++)
      smp((i % 2) ? 3'd1 : 3'd2, 0, 2'd0, 0);
    smp(3'd5, 0, 2'd0, 0);
    smp(3'd7, 0, 2'd0, 0);
    idle(3);
    check("t4_none", int'(cmd_if.cmd_valid), 0);
    gap();

    // 5: overflow with stalled consumer, then drain and clear
    cmd_if.cmd_ready = 1'b0;
    cfg_dwell = 12'd1; cfg_repeat = 12'd1;
    for (int i = 1; i <= 7; i++)
      smp(3'd1, i <= 4, 2'd1, i != 1);
    check("t5_ovf",   int'(overflow), 1);
    check("t5_drop",  int'(drop_cnt), 3);
    check("t5_valid", int'(cmd_if.cmd_valid), 1);
    enable = 1'b0;
    cmd_if.cmd_ready = 1'b1;
    idle(4);
    check("t5_drained", int'(cmd_if.cmd_valid), 0);
    check("t5_q", exp_q.size(), 0);
    @(negedge clk); clear_ovf = 1'b1;
    @(posedge clk); #1; clear_ovf = 1'b0;
    check("t5_clr_ovf",  int'(overflow), 0);
    check("t5_clr_drop", int'(drop_cnt), 0);
    gap();

    // 6: async reset mid-hold discards the queue and the dwell
    cmd_if.cmd_ready = 1'b0;
    cfg_dwell = 12'd3; cfg_repeat = 12'd0;
    smp(3'd1, 0, 2'd0, 0);
    smp(3'd1, 0, 2'd0, 0);
    smp(3'd1, 1, 2'd1, 0);
    smp(3'd1, 0, 2'd0, 0);
    check("t6_pre", int'(cmd_if.cmd_valid), 1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("t6_async", int'(cmd_if.cmd_valid), 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cmd_if.cmd_ready = 1'b1;
    smp(3'd1, 0, 2'd0, 0); check("t6_s1", int'(cmd_if.cmd_valid), 0);
    smp(3'd1, 0, 2'd0, 0); check("t6_s2", int'(cmd_if.cmd_valid), 0);
    smp(3'd1, 1, 2'd1, 0); check("t6_s3", int'(cmd_if.cmd_valid), 1);
    idle(3);
    check("t6_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
